// File: rtl/ef_spi_slave_apb_pkg.sv
// Shared register map, status/clear bit positions and config type for the EF_SPI wrappers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ef_spi_slave_apb_pkg;

    // Register word index, taken from PADDR[7:3]
    localparam logic [4:0] OFF_DATA   = 5'd0;   // 0x00
    localparam logic [4:0] OFF_CFG    = 5'd1;   // 0x08
    localparam logic [4:0] OFF_STATUS = 5'd2;   // 0x10
    localparam logic [4:0] OFF_IM     = 5'd6;   // 0x30
    localparam logic [4:0] OFF_IC     = 5'd7;   // 0x38

    // STATUS bit positions
    localparam int ST_RX_DONE = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_OVR     = 2;

    // IC / IM bit positions
    localparam int IC_RX_DONE = 0;
    localparam int IC_OVR     = 1;

    localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;

    // CFG register layout: bit0 cpol, bit1 cpha
    typedef struct packed {
        logic cpha;
        logic cpol;
    } cfg_t;

    function automatic logic [4:0] reg_idx(input logic [31:0] addr);
        return addr[7:3];
    endfunction

endpackage

// File: rtl/ef_spi_slave_apb_core.sv
// SPI target datapath: pin synchronizers, SCK edge detect, MSB-first shift registers, bit counter.
// Latency: pin change to internal event SYNC_STAGES+1 PCLK; rx_valid is a one-cycle combinational pulse.
// Backpressure: none; the external master owns timing, completed bytes are presented once.
module ef_spi_slave_apb_core
    import ef_spi_slave_apb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cfg_t       cfg,
    input  logic [7:0] tx_byte,
    input  logic       sck,
    input  logic       ssn,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] ssn_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sck_d;
    logic                   ssn_d;
    logic                   sck_sync;
    logic                   ssn_sync;
    logic                   mosi_sync;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;

    // Synchronizer chains plus one extra flop for edge detection; idle is SSn high, SCK low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= '0;
            ssn_sr  <= '1;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            ssn_d   <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            ssn_sr  <= {ssn_sr[SYNC_STAGES-2:0], ssn};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sck_d   <= sck_sync;
            ssn_d   <= ssn_sync;
        end
    end

    assign sck_sync  = sck_sr[SYNC_STAGES-1];
    assign ssn_sync  = ssn_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];

    logic frame_start;
    logic active;
    logic sck_rise;
    logic sck_fall;
    logic lead_ev;
    logic trail_ev;
    logic sample_ev;
    logic shift_ev;

    // SCK edges only count once the frame has been open for at least a cycle
    assign frame_start = ~ssn_sync & ssn_d;
    assign active      = ~ssn_sync & ~ssn_d;
    assign sck_rise    = sck_sync & ~sck_d;
    assign sck_fall    = ~sck_sync & sck_d;
    assign lead_ev     = active & (cfg.cpol ? sck_fall : sck_rise);
    assign trail_ev    = active & (cfg.cpol ? sck_rise : sck_fall);
    assign sample_ev   = cfg.cpha ? trail_ev : lead_ev;
    assign shift_ev    = cfg.cpha ? lead_ev  : trail_ev;

    assign rx_valid = sample_ev & (bit_cnt == 3'd7);
    assign rx_byte  = {rx_shift[6:0], mosi_sync};
    assign miso_oe  = ~ssn_sync;
    assign busy     = ~ssn_sync;

    // Shift engine: bit_cnt==0 at a shift edge marks a byte boundary, where TX_REG is reloaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'd0;
            tx_shift <= 8'd0;
            miso     <= 1'b0;
        end else if (frame_start) begin
            bit_cnt  <= 3'd0;
            tx_shift <= tx_byte;
            if (!cfg.cpha) begin
                miso     <= tx_byte[7];
                tx_shift <= {tx_byte[6:0], 1'b0};
            end
        end else if (ssn_sync) begin
            bit_cnt <= 3'd0;
        end else begin
            if (sample_ev) begin
                rx_shift <= {rx_shift[6:0], mosi_sync};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (shift_ev) begin
                if (bit_cnt == 3'd0) begin
                    miso     <= tx_byte[7];
                    tx_shift <= {tx_byte[6:0], 1'b0};
                end else begin
                    miso     <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/ef_spi_slave_apb.sv
// SPI target with APB register file: TX/RX data, mode config, RX_DONE/OVR flags and maskable IRQ.
// Latency: zero-wait APB; received byte visible in RX_BUF one PCLK after the core's rx_valid.
// Backpressure: none; an unread byte is overwritten and flagged as overrun.
module ef_spi_slave_apb
    import ef_spi_slave_apb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    input  logic        SCK,
    input  logic        SSn,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE
);

    logic [7:0] tx_reg;
    cfg_t       cfg;
    logic [1:0] im;
    logic [1:0] ic;
    logic [7:0] rx_buf;
    logic       rx_done;
    logic       ovr;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [4:0] idx;
    logic       wr;
    logic       ic_wr;
    logic       clr_done;
    logic       clr_ovr;
    logic       unused_bits;

    assign PREADY      = 1'b1;
    assign idx         = reg_idx(PADDR);
    assign wr          = PSEL & PENABLE & PWRITE & PREADY;
    assign ic_wr       = wr & (idx == OFF_IC);
    assign clr_done    = ic_wr & PWDATA[IC_RX_DONE];
    assign clr_ovr     = ic_wr & PWDATA[IC_OVR];
    assign unused_bits = ^{PADDR[31:8], PADDR[2:0], PWDATA[31:8]};

    ef_spi_slave_apb_core #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_core (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .cfg      (cfg),
        .tx_byte  (tx_reg),
        .sck      (SCK),
        .ssn      (SSn),
        .mosi     (MOSI),
        .miso     (MISO),
        .miso_oe  (MISO_OE),
        .busy     (busy),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );

    // Software-written registers; IC only holds its value for the cycle after the write
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_reg <= 8'd0;
            cfg    <= '0;
            im     <= 2'b00;
            ic     <= 2'b00;
        end else begin
            if (wr && idx == OFF_DATA) tx_reg <= PWDATA[7:0];
            if (wr && idx == OFF_CFG)  cfg    <= cfg_t'(PWDATA[1:0]);
            if (wr && idx == OFF_IM)   im     <= PWDATA[1:0];
            ic <= ic_wr ? PWDATA[1:0] : 2'b00;
        end
    end

    // Receive buffer and sticky flags; a new byte beats a same-cycle clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_buf  <= 8'd0;
            rx_done <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (rx_valid) rx_buf <= rx_byte;
            rx_done <= rx_valid | (rx_done & ~clr_done);
            ovr     <= (rx_valid & rx_done) | (ovr & ~clr_ovr);
        end
    end

    assign IRQ = (im[IC_RX_DONE] & rx_done) | (im[IC_OVR] & ovr);

    // Combinational read mux
    always_comb begin
        PRDATA = RD_UNMAPPED;
        case (idx)
            OFF_DATA:   PRDATA = {24'd0, rx_buf};
            OFF_CFG:    PRDATA = {30'd0, cfg};
            OFF_STATUS: PRDATA = {29'd0, ovr, busy, rx_done};
            OFF_IM:     PRDATA = {30'd0, im};
            OFF_IC:     PRDATA = {30'd0, ic};
            default:    PRDATA = RD_UNMAPPED;
        endcase
    end

endmodule

// File: tb/tb_ef_spi_slave_apb.sv
// Directed plus randomized bench for the SPI target: bench acts as SPI master and APB host.
// Latency: SCK half-period is H PCLK cycles, well inside the 8x oversampling limit.
// Backpressure: none on either side.
module tb_ef_spi_slave_apb;

    localparam int H = 8;
    localparam logic [31:0] A_DATA = 32'h00, A_CFG = 32'h08, A_STATUS = 32'h10;
    localparam logic [31:0] A_IM = 32'h30, A_IC = 32'h38;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, IRQ, SCK, SSn, MOSI, MISO, MISO_OE;

    int checks   = 0;
    int failures = 0;
    bit cpol = 1'b0;
    bit cpha = 1'b0;

    // Reference model: what software should observe
    logic [7:0] m_rx_buf;
    bit         m_done, m_ovr;
    logic [1:0] m_im;

    always #5 PCLK = ~PCLK;

    ef_spi_slave_apb #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .IRQ(IRQ),
        .SCK(SCK), .SSn(SSn), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE)
    );

    initial begin
        #3_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic exp_irq();
        return (m_im[0] & m_done) | (m_im[1] & m_ovr);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (m_done) m_ovr = 1'b1;
        m_done   = 1'b1;
        m_rx_buf = b;
    endtask

    task automatic clear_flags(input logic [1:0] v);
        apb_write(A_IC, {30'd0, v});
        if (v[0]) m_done = 1'b0;
        if (v[1]) m_ovr  = 1'b0;
    endtask

    task automatic set_im(input logic [1:0] v);
        apb_write(A_IM, {30'd0, v});
        m_im = v;
    endtask

    task automatic set_mode(input bit p, input bit h);
        cpol = p;
        cpha = h;
        SCK  = p;
        apb_write(A_CFG, {30'd0, h, p});
        tick(4);
    endtask

    // Compare software-visible state against the model (frame closed, so busy expected 0)
    task automatic check_all(input string tag);
        logic [31:0] d;
        apb_read(A_DATA, d);
        chk({tag, ".rx_buf"}, d, {24'd0, m_rx_buf});
        apb_read(A_STATUS, d);
        chk({tag, ".status"}, d, {29'd0, m_ovr, 1'b0, m_done});
        chk({tag, ".irq"}, {31'd0, IRQ}, {31'd0, exp_irq()});
    endtask

    task automatic ss_low();
        SSn = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        tick(H);
        SSn = 1'b1;
        tick(8);
    endtask

    // SPI master for one byte (or its first nbits), MSB first; collide issues an IC=1 write
    // timed to land on the same PCLK edge that the 8th sample reaches the flags (CPHA=0 only)
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit collide,
                        output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                MOSI = tx[i];
                tick(H);
                SCK   = ~cpol;
                rx[i] = MISO;
                if (collide && i == 0) begin
                    apb_write(A_IC, 32'd1);
                    tick(H - 3);
                end else begin
                    tick(H);
                end
                SCK = cpol;
            end else begin
                tick(H);
                SCK  = ~cpol;
                MOSI = tx[i];
                tick(H);
                SCK   = cpol;
                rx[i] = MISO;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  r, r2, tx, b0, b1;
        int          nb;

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0; SCK = 1'b0; SSn = 1'b1; MOSI = 1'b0;
        m_rx_buf = 8'd0; m_done = 1'b0; m_ovr = 1'b0; m_im = 2'b00;
        tick(3);

        // Reset state
        chk("rst.miso", {31'd0, MISO}, 32'd0);
        chk("rst.miso_oe", {31'd0, MISO_OE}, 32'd0);
        chk("rst.irq", {31'd0, IRQ}, 32'd0);
        chk("rst.pready", {31'd0, PREADY}, 32'd1);
        PRESETn = 1'b1;
        tick(2);
        apb_read(A_DATA, d);   chk("rst.data", d, 32'd0);
        apb_read(A_STATUS, d); chk("rst.status", d, 32'd0);
        apb_read(A_CFG, d);    chk("rst.cfg", d, 32'd0);
        apb_read(A_IM, d);     chk("rst.im", d, 32'd0);
        apb_read(A_IC, d);     chk("rst.ic", d, 32'd0);
        apb_read(32'h18, d);   chk("unmapped", d, 32'hDEAD_BEEF);

        // Mode 0 basic exchange, with busy observed mid-frame
        apb_write(A_DATA, 32'hA5);
        ss_low();
        apb_read(A_STATUS, d);
        chk("m0.busy", d, 32'h2);
        chk("m0.miso_oe", {31'd0, MISO_OE}, 32'd1);
        xfer(8'h3C, 8, 1'b0, r);
        ss_high();
        model_byte(8'h3C);
        chk("m0.master_rx", {24'd0, r}, 32'hA5);
        check_all("m0");

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            clear_flags(2'b11);
            apb_write(A_DATA, 32'h81);
            ss_low();
            xfer(8'h7E, 8, 1'b0, r);
            ss_high();
            model_byte(8'h7E);
            chk($sformatf("mode%0d.master_rx", m), {24'd0, r}, 32'h81);
            check_all($sformatf("mode%0d", m));
        end

        // Two bytes under one SSn without a read: overrun
        set_mode(1'b0, 1'b0);
        clear_flags(2'b11);
        set_im(2'b10);
        apb_write(A_DATA, 32'h5A);
        ss_low();
        xfer(8'h11, 8, 1'b0, r);
        xfer(8'h22, 8, 1'b0, r2);
        ss_high();
        model_byte(8'h11);
        model_byte(8'h22);
        chk("b2b.master_rx0", {24'd0, r}, 32'h5A);
        chk("b2b.master_rx1", {24'd0, r2}, 32'h5A);
        check_all("b2b");

        // Aborted partial frame, then a full one
        clear_flags(2'b11);
        set_im(2'b00);
        ss_low();
        xfer(8'hF0, 5, 1'b0, r);
        ss_high();
        check_all("partial");
        ss_low();
        xfer(8'h55, 8, 1'b0, r);
        ss_high();
        model_byte(8'h55);
        check_all("after_partial");

        // IRQ on RX_DONE, clear via IC, then clear colliding with a new byte
        clear_flags(2'b11);
        set_im(2'b01);
        ss_low();
        xfer(8'h99, 8, 1'b0, r);
        ss_high();
        model_byte(8'h99);
        check_all("irq_set");
        clear_flags(2'b01);
        chk("irq_clr", {31'd0, IRQ}, {31'd0, exp_irq()});
        ss_low();
        xfer(8'h6B, 8, 1'b1, r);
        ss_high();
        m_done = 1'b0;
        model_byte(8'h6B);
        check_all("collide");

        // Randomized frames across modes, masks and byte counts
        for (int it = 0; it < 8; it++) begin
            set_mode(1'($urandom_range(1)), 1'($urandom_range(1)));
            set_im(2'($urandom_range(3)));
            clear_flags(2'($urandom_range(3)));
            tx = 8'($urandom);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            nb = $urandom_range(1, 2);
            apb_write(A_DATA, {24'd0, tx});
            ss_low();
            xfer(b0, 8, 1'b0, r);
            model_byte(b0);
            chk($sformatf("rnd%0d.master_rx0", it), {24'd0, r}, {24'd0, tx});
            if (nb == 2) begin
                xfer(b1, 8, 1'b0, r2);
                model_byte(b1);
                chk($sformatf("rnd%0d.master_rx1", it), {24'd0, r2}, {24'd0, tx});
            end
            ss_high();
            check_all($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a byte
        set_mode(1'b0, 1'b0);
        apb_write(A_DATA, 32'h3A);
        ss_low();
        xfer(8'hFF, 4, 1'b0, r);
        PRESETn = 1'b0;
        tick(1);
        chk("rstmid.miso_oe", {31'd0, MISO_OE}, 32'd0);
        apb_read(A_STATUS, d);
        chk("rstmid.status", d, 32'd0);
        chk("rstmid.irq", {31'd0, IRQ}, 32'd0);
        SSn = 1'b1;
        SCK = 1'b0;
        tick(4);
        PRESETn = 1'b1;
        m_rx_buf = 8'd0; m_done = 1'b0; m_ovr = 1'b0; m_im = 2'b00;
        tick(4);
        apb_write(A_DATA, 32'h96);
        ss_low();
        xfer(8'hC3, 8, 1'b0, r);
        ss_high();
        model_byte(8'hC3);
        chk("rstmid.master_rx", {24'd0, r}, 32'h96);
        check_all("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
